// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared Wishbone B4 cycle/burst type encodings and slave state type
package wishbone_pkg;

  // Cycle type identifiers (CTI_I)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Burst type extensions (BTE_I)
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_TERM
  } wb_state_e;

  // True for cycle types that announce another beat after the current one
  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// rtl/wb_burst_addr_gen.sv - combinational next word address for constant, linear and wrapping bursts
module wb_burst_addr_gen
  import wishbone_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0] cur_addr,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_addr,
  output logic          out_of_range
);

  // One extra bit so a linear step past the top word shows up as a carry
  logic [AW:0] inc;
  assign inc = {1'b0, cur_addr} + {{AW{1'b0}}, 1'b1};

  // Pick the next beat: constant holds, linear increments, wraps keep the block-aligned upper bits
  always_comb begin
    next_addr    = cur_addr;
    out_of_range = 1'b0;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: begin
          next_addr    = inc[AW-1:0];
          out_of_range = inc[AW];
        end
        BTE_WRAP4:  next_addr = {cur_addr[AW-1:2], inc[1:0]};
        BTE_WRAP8:  next_addr = {cur_addr[AW-1:3], inc[2:0]};
        BTE_WRAP16: next_addr = {cur_addr[AW-1:4], inc[3:0]};
        default:    next_addr = cur_addr;
      endcase
    end
  end

endmodule

// File: rtl/wishbone_slave_mem.sv
// rtl/wishbone_slave_mem.sv - Wishbone B4 slave RAM with wait states, registered-feedback bursts, ERR and RTY
module wishbone_slave_mem
  import wishbone_pkg::*;
#(
  parameter int                   WB_ADDR_W = 32,
  parameter int                   WB_DATA_W = 32,
  parameter int                   MEM_AW    = 8,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [WB_ADDR_W-1:0]   ADR_I,
  input  logic [WB_DATA_W-1:0]   DAT_I,
  output logic [WB_DATA_W-1:0]   DAT_O,
  input  logic [WB_DATA_W/8-1:0] SEL_I,
  input  logic                   WE_I,
  input  logic                   STB_I,
  input  logic                   CYC_I,
  input  logic [2:0]             CTI_I,
  input  logic [1:0]             BTE_I,
  output logic                   ACK_O,
  output logic                   ERR_O,
  output logic                   RTY_O,
  input  logic [3:0]             cfg_wait,
  input  logic                   cfg_rty,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int SEL_W = WB_DATA_W / 8;
  localparam int DEPTH = 1 << MEM_AW;

  wb_state_e              state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MEM_AW-1:0]      beat_q, beat_d;
  logic [WB_DATA_W-1:0]   dat_q, dat_d;
  logic                   term_err_q, term_err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [WB_DATA_W-1:0]   mem_q [DEPTH];

  logic                   req;
  logic [WB_ADDR_W-1:0]   offset;
  logic                   in_window;
  logic [MEM_AW-1:0]      req_word;
  logic [MEM_AW-1:0]      next_beat;
  logic                   next_oor;
  logic                   wr_en;
  logic                   unused_ok;

  assign req       = STB_I & CYC_I;
  // Addresses below the base wrap to a huge offset and so fall out of the window too
  assign offset    = ADR_I - BASE_ADDR;
  assign in_window = (offset[WB_ADDR_W-1:MEM_AW+2] == '0);
  assign req_word  = offset[MEM_AW+1:2];
  assign unused_ok = &{1'b0, offset[1:0]};

  wb_burst_addr_gen #(
    .AW (MEM_AW)
  ) u_addr_gen (
    .cur_addr     (beat_q),
    .cti          (CTI_I),
    .bte          (BTE_I),
    .next_addr    (next_beat),
    .out_of_range (next_oor)
  );

  // A beat commits only while it is being acknowledged; reset suppresses it
  assign wr_en = (state_q == ST_ACK) & STB_I & WE_I & ~RST_I;

  assign ACK_O   = (state_q == ST_ACK);
  assign ERR_O   = (state_q == ST_TERM) &  term_err_q;
  assign RTY_O   = (state_q == ST_TERM) & ~term_err_q;
  assign busy    = (state_q != ST_IDLE);
  assign DAT_O   = dat_q;
  assign err_cnt = err_cnt_q;

  // Next-state and datapath decisions for the request/termination sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    dat_d      = dat_q;
    term_err_d = term_err_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          beat_d = req_word;
          if (!in_window) begin
            state_d    = ST_TERM;
            term_err_d = 1'b1;
          end else if (cfg_rty) begin
            state_d    = ST_TERM;
            term_err_d = 1'b0;
          end else if (cfg_wait == 4'd0) begin
            state_d = ST_ACK;
            dat_d   = mem_q[req_word];
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cfg_wait;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_ACK;
            dat_d   = mem_q[beat_q];
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (req) begin
          case (CTI_I)
            CTI_CONST, CTI_INCR: begin
              if (next_oor) begin
                state_d    = ST_TERM;
                term_err_d = 1'b1;
              end else begin
                state_d = ST_ACK;
                beat_d  = next_beat;
                dat_d   = mem_q[next_beat];
              end
            end
            CTI_CLASSIC, CTI_END: state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
          endcase
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        if (term_err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and read-data registers with synchronous reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      beat_q     <= '0;
      dat_q      <= '0;
      term_err_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      dat_q      <= dat_d;
      term_err_q <= term_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Byte-lane RAM writes; contents are deliberately left unreset
  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (SEL_I[b]) begin
          mem_q[beat_q][8*b +: 8] <= DAT_I[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// tb/tb_wishbone_slave_mem.sv - self-checking bench for wishbone_slave_mem against a word-array model
module tb_wishbone_slave_mem;
  import wishbone_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty, busy;
  logic [3:0]  cfg_wait;
  logic        cfg_rty;
  logic [7:0]  err_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mdl [256];
  int          mdl_err  = 0;

  always #5 clk = ~clk;

  wishbone_slave_mem #(
    .WB_ADDR_W (32),
    .WB_DATA_W (32),
    .MEM_AW    (8),
    .BASE_ADDR (32'h0)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .ADR_I    (adr),
    .DAT_I    (dat_i),
    .DAT_O    (dat_o),
    .SEL_I    (sel),
    .WE_I     (we),
    .STB_I    (stb),
    .CYC_I    (cyc),
    .CTI_I    (cti),
    .BTE_I    (bte),
    .ACK_O    (ack),
    .ERR_O    (err),
    .RTY_O    (rty),
    .cfg_wait (cfg_wait),
    .cfg_rty  (cfg_rty),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    adr = 32'h0; dat_i = 32'h0; sel = 4'h0;
  endtask

  // One request of nb beats; nb==1 is a classic cycle, otherwise the last beat carries CTI_END
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] mode,
                         input logic [1:0] bt, input int nb, input logic [3:0] sl, input bit seqdata);
    int          idx, nidx, lat, exp_lat, n;
    bit          oow, noow;
    logic [31:0] d;
    oow = (addr >= 32'h400);
    idx = int'(addr[9:2]);
    d   = seqdata ? 32'd1 : $urandom;
    adr = addr; dat_i = d; sel = sl; we = wr; stb = 1'b1; cyc = 1'b1; bte = bt;
    cti = (nb == 1) ? CTI_CLASSIC : mode;
    exp_lat = (oow || cfg_rty) ? 0 : int'(cfg_wait);
    tick();
    lat = 0;
    while ((ack | err | rty) !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("first_term_latency", lat, exp_lat);
    if (lat >= 20) begin
      bus_idle();
      return;
    end
    if (oow) begin
      chk("oow_err_term", {ack, err, rty}, 3'b010);
      if (mdl_err < 255) mdl_err++;
    end else if (cfg_rty) begin
      chk("rty_term", {ack, err, rty}, 3'b001);
    end else begin
      for (int b = 0; b < nb; b++) begin
        chk("beat_ack", {ack, err, rty}, 3'b100);
        if (!wr) chk("beat_rdata", dat_o, mdl[idx]);
        else for (int k = 0; k < 4; k++) if (sl[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
        if (b == nb - 1) break;
        noow = 1'b0;
        if (mode == CTI_CONST) nidx = idx;
        else if (bt == BTE_LINEAR) begin
          nidx = idx + 1;
          noow = (nidx >= 256);
        end else begin
          n    = 2 << bt;
          nidx = (idx / n) * n + (idx + 1) % n;
        end
        tick();
        if (noow) begin
          chk("burst_exit_err", {ack, err, rty}, 3'b010);
          if (mdl_err < 255) mdl_err++;
          break;
        end
        idx   = nidx;
        d     = seqdata ? 32'(b + 2) : $urandom;
        adr   = 32'(idx) << 2;
        dat_i = d;
        cti   = (b + 1 == nb - 1) ? CTI_END : mode;
      end
    end
    tick();
    bus_idle();
    chk("back_to_idle", {ack, err, rty, busy}, 4'b0000);
    chk("err_cnt", {24'h0, err_cnt}, 32'(mdl_err));
  endtask

  initial begin
    rst = 1'b1; cfg_wait = 4'd0; cfg_rty = 1'b0;
    bus_idle();
    tick();
    tick();
    chk("reset_terms_busy", {ack, err, rty, busy}, 4'b0000);
    chk("reset_dat_o", dat_o, 32'h0);
    chk("reset_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    tick();

    // Fill the whole RAM with one linear write burst so the model is fully known
    do_xfer(1'b1, 32'h0, CTI_INCR, BTE_LINEAR, 256, 4'hF, 1'b0);

    // Partial write with wait states, then read back
    mdl[4] = 32'h11223344;
    adr = 32'h10; dat_i = 32'h11223344; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1; cti = CTI_CLASSIC;
    tick(); tick(); bus_idle(); tick();
    cfg_wait = 4'd2;
    do_xfer(1'b1, 32'h10, CTI_CLASSIC, BTE_LINEAR, 1, 4'b0011, 1'b0);
    cfg_wait = 4'd0;
    mdl[4][31:16] = 16'h1122;
    do_xfer(1'b0, 32'h10, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);

    // Wrap-4 read burst 6,7,4,5; constant write burst 1,2,3 to word 8
    do_xfer(1'b0, 32'h18, CTI_INCR, BTE_WRAP4, 4, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h20, CTI_CONST, BTE_LINEAR, 3, 4'hF, 1'b1);
    do_xfer(1'b0, 32'h20, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    chk("const_burst_last_data", dat_o, 32'd3);

    // Out-of-window write, then word 0 must be untouched; linear burst running off the end
    do_xfer(1'b1, 32'h400, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h0, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h3F8, CTI_INCR, BTE_LINEAR, 4, 4'hF, 1'b0);
    do_xfer(1'b0, 32'h3F8, CTI_INCR, BTE_LINEAR, 2, 4'hF, 1'b0);

    // Retry on demand, and ERR winning over RTY
    cfg_rty = 1'b1;
    do_xfer(1'b0, 32'h44, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    do_xfer(1'b1, 32'h800, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    cfg_rty = 1'b0;

    // Reset while waiting: no termination, no write
    cfg_wait = 4'd5;
    adr = 32'h40; dat_i = 32'hCAFEF00D; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 1'b1; cti = CTI_CLASSIC;
    tick();
    tick();
    chk("wait_no_term", {ack, err, rty, busy}, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_idle();
    chk("rst_mid_terms_busy", {ack, err, rty, busy}, 4'b0000);
    chk("rst_mid_err_cnt", {24'h0, err_cnt}, 32'h0);
    chk("rst_mid_dat_o", dat_o, 32'h0);
    mdl_err = 0;
    cfg_wait = 4'd0;
    tick();
    do_xfer(1'b0, 32'h40, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);

    // Randomised mix of reads, writes, burst kinds, wait states and retries
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      cfg_wait = 4'($urandom_range(0, 3));
      cfg_rty  = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 9) == 0) ? (32'h400 + ($urandom & 32'hFFFF)) :
          ((32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3)));
      do_xfer(1'($urandom), a, ($urandom_range(0, 1) == 1) ? CTI_CONST : CTI_INCR,
              2'($urandom), $urandom_range(1, 6), 4'($urandom), 1'b0);
    end
    cfg_rty = 1'b0;
    cfg_wait = 4'd0;

    // Drive the ERR counter into saturation
    for (int i = 0; i < 256; i++) begin
      do_xfer(1'b1, 32'h1000, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 1'b0);
    end
    chk("err_cnt_saturated", {24'h0, err_cnt}, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
